// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic unit.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

  // Counter must hold values 0..w, so it needs clog2(w+1) bits.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register, LSB presented first.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);

  logic [WIDTH-1:0] r;

  // Load takes priority so a back-to-back accept replaces stale bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r <= '0;
    else if (load)  r <= d;
    else if (shift) r <= r >> 1;
  end

  assign q0 = r[0];

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: parallel load, LSB-first processing,
// result collected MSB-in and published only at completion.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             hold,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_chk
    $error("serial_addsub: WIDTH out of range");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             mode;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             a0, b0, bb, s, cy;
  logic             acc, step, last;

  assign acc  = start && (state != SHIFT);
  assign step = (state == SHIFT) && !hold;
  assign last = (cnt == CW'(WIDTH - 1));

  piso_shift_reg #(.WIDTH(WIDTH)) u_a (
    .clk(clk), .rst(rst), .load(acc), .shift(step), .d(a_in), .q0(a0)
  );
  piso_shift_reg #(.WIDTH(WIDTH)) u_b (
    .clk(clk), .rst(rst), .load(acc), .shift(step), .d(b_in), .q0(b0)
  );

  // Full-adder slice; subtract inverts B and relies on carry preset to 1.
  always_comb begin
    bb      = b0 ^ mode;
    s       = a0 ^ bb ^ c;
    cy      = (a0 & bb) | (a0 & c) | (bb & c);
    res_nxt = res >> 1;
    res_nxt[WIDTH-1] = s;
  end

  // FSM, bit counter and serial datapath state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      c     <= 1'b0;
      mode  <= 1'b0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            cnt   <= '0;
            c     <= sub;
            mode  <= sub;
            res   <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          if (!hold) begin
            res <= res_nxt;
            c   <= cy;
            cnt <= cnt + CW'(1);
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: publish result and flags only on the final bit.
  // c at that point is the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (step && last) begin
      sum       <= res_nxt;
      carry_out <= cy;
      overflow  <= c ^ cy;
    end
  end

endmodule
